// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor: operation
// encoding and the stage-0 operand/carry preprocessing rules.
package adder_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    ADDC = 2'b10,
    SUBB = 2'b11
  } add_op_t;

  // Subtraction is done as a + ~b + c0, so only B needs inverting.
  function automatic logic is_sub(input add_op_t op);
    return (op == SUB) || (op == SUBB);
  endfunction

  function automatic logic carry_in(input add_op_t op, input logic cin);
    logic c0;
    case (op)
      ADD:     c0 = 1'b0;
      SUB:     c0 = 1'b1;
      ADDC:    c0 = cin;
      SUBB:    c0 = ~cin;
      default: c0 = 1'b0;
    endcase
    return c0;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple-carry adder; one instance per pipeline stage.
module adder_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] carry;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[SLICE];
  end

endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep pipelined adder/subtractor: stage k adds slice k with the carry
// registered by stage k-1; skew registers carry operands and partial sums along.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  add_op_t          in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  typedef logic [WIDTH-1:0] word_t;

  if ((WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  word_t             a_q   [STAGES];
  word_t             b_q   [STAGES];
  word_t             sum_q [STAGES];
  word_t             a_d   [STAGES];
  word_t             b_d   [STAGES];
  word_t             sum_d [STAGES];
  logic [STAGES-1:0] carry_q, carry_d;
  logic [STAGES-1:0] valid_q, valid_d;
  logic              zero_q, zero_d;
  logic              advance;

  assign advance  = !valid_q[LAST] || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             c_in;
    word_t            s_in;
    word_t            s_loc;
    logic [SLICE-1:0] s_slice;

    if (k == 0) begin : g_head
      assign a_d[k]     = in_a;
      assign b_d[k]     = is_sub(in_op) ? ~in_b : in_b;
      assign c_in       = carry_in(in_op, in_cin);
      assign s_in       = '0;
      assign valid_d[k] = in_valid && advance;
    end else begin : g_body
      assign a_d[k]     = a_q[k-1];
      assign b_d[k]     = b_q[k-1];
      assign c_in       = carry_q[k-1];
      assign s_in       = sum_q[k-1];
      assign valid_d[k] = valid_q[k-1];
    end

    adder_slice #(.SLICE(SLICE)) u_slice (
      .a    (a_d[k][k*SLICE +: SLICE]),
      .b    (b_d[k][k*SLICE +: SLICE]),
      .cin  (c_in),
      .sum  (s_slice),
      .cout (carry_d[k])
    );

    always_comb begin
      s_loc                      = s_in;
      s_loc[k*SLICE +: SLICE]    = s_slice;
    end
    assign sum_d[k] = s_loc;
  end

  assign zero_d = ~|sum_d[LAST];

  // NOTE: state uses non-blocking assignments so every stage samples its predecessor's old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Datapath registers are reset too, so flags never see X while idle.
      valid_q <= '0;
      carry_q <= '0;
      zero_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      if (flush) begin
        valid_q <= '0;
      end else if (advance) begin
        valid_q <= valid_d;
      end
      if (advance) begin
        carry_q <= carry_d;
        zero_q  <= zero_d;
        for (int k = 0; k < STAGES; k++) begin
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          sum_q[k] <= sum_d[k];
        end
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = carry_q[LAST];
  assign out_zero  = zero_q;
  assign out_ovf   = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                     (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: stimulus pushes expected results from an arithmetic model,
// a monitor pops and compares on every out_valid && out_ready.
module tb_pipelined_adder;
  import adder_pkg::*;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_cin;
  logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [63:0] in_a, in_b, out_sum;
  add_op_t     in_op;

  exp_t sb_q[$];
  int   n_chk = 0, n_pass = 0, n_pop = 0;
  int   cyc = 0, last_pop = -10, run_len = 0;
  bit   sweep_go = 1'b0;
  int   sweep_done = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(64), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: exact integer arithmetic in 66 bits, then read off the flags.
  function automatic exp_t model(input add_op_t op, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin);
    logic [65:0] ua, ub, sa, sb, c, ur, sr;
    exp_t e;
    ua = {2'b00, a};
    ub = {2'b00, b};
    sa = {{2{a[63]}}, a};
    sb = {{2{b[63]}}, b};
    c  = {65'd0, cin};
    case (op)
      ADD:     begin ur = ua + ub;     sr = sa + sb;     end
      SUB:     begin ur = ua - ub;     sr = sa - sb;     end
      ADDC:    begin ur = ua + ub + c; sr = sa + sb + c; end
      default: begin ur = ua - ub - c; sr = sa - sb - c; end
    endcase
    e.sum  = ur[63:0];
    e.cout = (op == ADD || op == ADDC) ? ur[64] : ~ur[65];
    e.ovf  = !(sr[65:63] == 3'b000 || sr[65:63] == 3'b111);
    e.zero = (ur[63:0] == 64'd0);
    return e;
  endfunction

  // Monitor: every consumed result must match the oldest outstanding expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!rst && out_valid && out_ready) begin
      run_len  = (cyc == last_pop + 1) ? run_len + 1 : 1;
      last_pop = cyc;
      n_pop++;
      if (sb_q.size() == 0) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("scoreboard", {out_sum, out_cout, out_ovf, out_zero}, e);
      end
    end
  end

  // Present one op (called at posedge+1); record it once the DUT takes it.
  task automatic send(input add_op_t op, input logic [63:0] a, input logic [63:0] b, input logic cin);
    int w = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cin = cin;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1'b1);
    sb_q.push_back(model(op, a, b, cin));
    @(posedge clk); #1;
  endtask

  // Latency counts rising edges from the accept edge (inclusive) until out_valid shows.
  task automatic run_latency(input string name, input add_op_t op, input logic [63:0] a,
                             input logic [63:0] b, input logic cin, input exp_t want);
    int n = 0;
    check({name, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cin = cin;
    sb_q.push_back(model(op, a, b, cin));
    do begin
      @(posedge clk); n++; #1 in_valid = 1'b0;
    end while (!out_valid && n < 100);
    check({name, "_latency"}, n, 4);
    check({name, "_result"}, {out_sum, out_cout, out_ovf, out_zero}, want);
  endtask

  // Parameter sweep: all-ones + 1 through other shapes, latency must equal STAGES.
  localparam int SW_W [5] = '{64, 64, 64, 64, 32};
  localparam int SW_S [5] = '{1, 2, 8, 64, 4};

  for (genvar g = 0; g < 5; g++) begin : g_sweep
    localparam int W = SW_W[g];
    localparam int S = SW_S[g];
    logic [W-1:0] a, b, sum;
    logic         iv, ir, ov, co, of, z;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .flush(1'b0), .in_valid(iv), .in_ready(ir),
      .in_a(a), .in_b(b), .in_op(ADD), .in_cin(1'b0),
      .out_valid(ov), .out_ready(1'b1), .out_sum(sum),
      .out_cout(co), .out_ovf(of), .out_zero(z)
    );

    initial begin
      int n = 0;
      iv = 1'b0; a = '0; b = '0;
      wait (sweep_go);
      @(posedge clk); #1;
      a  = '1;
      b  = {{(W-1){1'b0}}, 1'b1};
      iv = 1'b1;
      do begin
        @(posedge clk); n++; #1 iv = 1'b0;
      end while (!ov && n < 200);
      check($sformatf("sweep_w%0d_s%0d_latency", W, S), n, S);
      check($sformatf("sweep_w%0d_s%0d_sum", W, S), sum, 0);
      check($sformatf("sweep_w%0d_s%0d_flags", W, S), {co, of, z, ir}, 4'b1011);
      sweep_done++;
    end
  end

  initial begin
    int base;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_op = ADD; in_cin = 1'b0; out_ready = 1'b1;
    #1;
    check("reset_outputs", {out_valid, out_sum, out_cout, out_ovf, out_zero}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("reset_in_ready", in_ready, 1'b1);

    sweep_go = 1'b1;
    for (int i = 0; i < 300 && sweep_done < 5; i++) @(posedge clk);
    check("sweep_complete", sweep_done, 5);
    @(posedge clk); #1;

    // Carry ripples across every slice boundary.
    run_latency("all_ones_plus_one", ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                '{sum: 64'd0, cout: 1'b1, ovf: 1'b0, zero: 1'b1});
    @(posedge clk); #1;
    run_latency("min_minus_one", SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0,
                '{sum: 64'h7FFF_FFFF_FFFF_FFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0});
    @(posedge clk); #1;
    run_latency("max_plus_one", ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                '{sum: 64'h8000_0000_0000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0});
    repeat (3) @(posedge clk); #1;

    // Back-to-back stream with directed ADDC/SUBB carry cases mixed in.
    base = n_pop;
    for (int i = 0; i < 8; i++) begin
      if (i == 2)      send(ADDC, 64'd5, 64'd3, 1'b1);
      else if (i == 5) send(SUBB, 64'd5, 64'd3, 1'b1);
      else send(add_op_t'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk); #1;
    check("stream_count", n_pop - base, 8);
    check("stream_back_to_back", run_len, 8);

    // Backpressure: fill the pipeline, hold, then drain.
    out_ready = 1'b0;
    base = n_pop;
    for (int i = 0; i < 4; i++)
      send(add_op_t'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
           1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {in_ready, out_valid}, 2'b01);
      check("stall_hold", {out_sum, out_cout, out_ovf, out_zero}, sb_q[0]);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("drain_count", n_pop - base, 4);
    check("drain_in_order_run", run_len, 4);
    check("drain_empty", sb_q.size(), 0);

    // Flush with three ops in flight and a fresh input offered in the same cycle.
    for (int i = 0; i < 3; i++)
      send(ADD, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_op = SUB; in_a = 64'd9; in_b = 64'd4;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    check("flush_squash", out_valid, 1'b0);
    run_latency("after_flush", ADD, 64'd100, 64'd23, 1'b0, model(ADD, 64'd100, 64'd23, 1'b0));
    repeat (2) @(posedge clk); #1;

    // Asynchronous reset between edges with a full, stalled pipeline.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(ADDC, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {out_valid, out_sum, out_cout, out_ovf, out_zero}, 0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    #1 check("post_reset_ready", {in_ready, out_valid}, 2'b10);
    run_latency("after_reset", SUBB, 64'd0, 64'd0, 1'b1, model(SUBB, 64'd0, 64'd0, 1'b1));

    repeat (10) @(posedge clk);
    check("final_scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined two-operand integer adder/subtractor for the execute stage.
- Splits a WIDTH-bit carry chain into STAGES equal slices, one slice per pipeline stage. The carry is registered between stages, so the critical path is WIDTH/STAGES full-adder cells.
- Handshakes: valid/ready on input and output, plus a synchronous flush.
- Produces sum, carry-out, signed overflow and zero flags.

Parameters:
- WIDTH, 64: operand/result width in bits. Must satisfy WIDTH % STAGES == 0.
- STAGES, 4: number of pipeline stages. Range 1..WIDTH. Latency equals STAGES.
- SLICE, WIDTH/STAGES: derived local parameter, bits added per stage. Not overridable.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous squash of all in-flight operations
- in_valid  input  1  operands/op present
- in_ready  output  1  pipeline can accept this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  adder_pkg::add_op_t (2 bits)  ADD, SUB, ADDC (add with in_cin), SUBB (subtract with borrow)
- in_cin  input  1  carry/borrow-in, used only by ADDC/SUBB
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry-out of MSB. For SUB/SUBB, 1 = no borrow.
- out_ovf  output  1  signed overflow
- out_zero  output  1  out_sum == 0

Behaviour:
- Reset (async, rst=1): all stage valid bits cleared. out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0. in_ready=1 once rst deasserts.
- Operand preprocessing in stage 0:
  - b_eff = in_b for ADD/ADDC; b_eff = ~in_b for SUB/SUBB.
  - c0 = 0 for ADD, 1 for SUB, in_cin for ADDC, ~in_cin for SUBB.
- Stage k (0..STAGES-1):
  - Adds slice k of A and b_eff, using the carry registered from stage k-1 (c0 for k=0).
  - Registers the slice result and its carry-out.
  - Upper, not-yet-added slices of A and b_eff are carried forward in skew registers. Already-computed lower sum slices are carried forward too.
- Final stage outputs:
  - out_cout = carry-out of slice STAGES-1.
  - out_ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]).
  - out_zero = ~|out_sum. Computed combinationally from the final register, or registered with it; either way it must be valid in the same cycle as out_valid.
- Flow control:
  - Global enable: advance = !out_valid || out_ready, and in_ready = advance.
  - When advance=0, every stage register (data and valid) holds.
  - When advance=1, each stage loads from its predecessor, and stage 0 loads valid = in_valid && in_ready.
  - No bubble collapsing.
- Throughput and latency: one op per cycle when unstalled. A result appears STAGES cycles after acceptance.
- STAGES=1: a single registered full-width ripple add, latency 1.
- Output stability: while out_valid=1 and out_ready=0, out_sum/out_cout/out_ovf/out_zero are held stable.
- Flush:
  - flush=1 clears all valid bits at the next edge regardless of advance. Data registers may keep stale values.
  - An input offered in the same cycle as flush is dropped.
  - flush has priority over out_ready. A result presented in the flush cycle counts as consumed only if out_ready=1 in that cycle.
- rst asserted mid-operation: all in-flight ops are lost immediately and outputs go to their reset values.
- Width rules:
  - Arithmetic is modulo 2^WIDTH.
  - The slice adder is SLICE+1 bits wide; its top bit is the slice carry.
  - No X propagation from data registers of invalid stages to flags while out_valid=0. All outputs are driven from reset-initialised registers.

Decomposition:
- adder_pkg:
  - add_op_t enum {ADD=2'b00, SUB=2'b01, ADDC=2'b10, SUBB=2'b11}.
  - function is_sub(op).
  - function carry_in(op, cin).
- Sub-module adder_slice (combinational, parameter SLICE):
  - Inputs a, b, cin; outputs sum[SLICE-1:0], cout.
  - Ripple of full-adder cells.
  - Instantiated STAGES times via generate.
- pipelined_adder contains the stage registers, skew registers, valid chain and flag logic.

Test Plan:
- WIDTH=64, STAGES=4: ADD 0xFFFF_FFFF_FFFF_FFFF + 1 → out_sum=0, out_cout=1, out_zero=1, out_ovf=0. Result exactly 4 cycles after the accept edge; carry crosses all slice boundaries.
- SUB 0x8000_0000_0000_0000 − 1 → out_sum=0x7FFF_FFFF_FFFF_FFFF, out_ovf=1, out_cout=1. ADD 0x7FFF_FFFF_FFFF_FFFF + 1 → out_sum=0x8000_0000_0000_0000, out_ovf=1.
- Back-to-back stream of 8 random ops (mixed ADD/SUB/ADDC/SUBB) with out_ready=1 → one result per cycle, in order, matching a reference model. ADDC 5+3 with cin=1 → 9. SUBB 5−3 with cin=1 → 1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with a full pipeline → in_ready=0 and outputs stable throughout.
  - Release → 4 queued results drain in order with no loss or duplication.
- Flush with 3 ops in flight and in_valid=1 in the same cycle → no out_valid for any of them. A new op accepted next cycle emerges 4 cycles later.
- Async reset mid-stream, plus parameter sweep:
  - rst pulse between clock edges → out_valid drops immediately, all outputs 0.
  - Re-run the first scenario with STAGES ∈ {1, 2, 8, 64} and WIDTH=32, STAGES=4; latency equals STAGES in each case.
